// File: rtl/gt_latency_pkg.sv
// Shared types and helpers for the GT link latency monitor.
// Holds the checker state encoding and the IDLE word builder used on TX and RX.
package gt_latency_pkg;

    localparam int unsigned c_MAX_BYTES   = 4;
    localparam int unsigned c_LANE_W      = 16;
    localparam logic [1:0]  c_IDLE_LANE_K = 2'b10;

    typedef enum logic [1:0] {
        ST_UNALIGNED = 2'd0,
        ST_BLIND     = 2'd1,
        ST_SYNC      = 2'd2,
        ST_CHECK     = 2'd3
    } chk_state_e;

    typedef struct packed {
        logic [8*c_MAX_BYTES-1:0] data;
        logic [c_MAX_BYTES-1:0]   k;
    } gt_word_t;

    // Replicates one 16-bit IDLE lane across the active lanes; unused lanes stay zero.
    function automatic gt_word_t idle_word(int unsigned bytes, logic [15:0] idle, logic [1:0] idle_k);
        gt_word_t w;
        w = '0;
        for (int unsigned l = 0; l < c_MAX_BYTES / 2; l++) begin
            if (l < bytes / 2) begin
                w.data[c_LANE_W*l +: c_LANE_W] = idle;
                w.k[2*l +: 2]                  = idle_k;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/gt_link_latency_monitor_if.sv
// GT user-port bundle between the latency monitor and the transceiver wrapper.
interface gt_link_latency_monitor_if #(
    parameter int unsigned g_BYTES = 2
);
    logic [8*g_BYTES-1:0] tx_data_o;
    logic [g_BYTES-1:0]   tx_k_o;
    logic [8*g_BYTES-1:0] rx_data_i;
    logic [g_BYTES-1:0]   rx_k_i;
    logic                 rx_aligned_i;
    logic                 rx_realign_o;

    modport master (
        output tx_data_o, tx_k_o, rx_realign_o,
        input  rx_data_i, rx_k_i, rx_aligned_i
    );

    modport slave (
        input  tx_data_o, tx_k_o, rx_realign_o,
        output rx_data_i, rx_k_i, rx_aligned_i
    );
endinterface

// File: rtl/gt_latency_stats.sv
// Latency statistics accumulator: min/max/sum/count/errors with saturation,
// plus the good-run counter that qualifies pass_o.
module gt_latency_stats #(
    parameter int unsigned g_NUM_SUCCESSFUL_DATA = 1000
) (
    input  logic        usrclk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        sample_i,
    input  logic [15:0] latency_i,
    input  logic        err_i,
    input  logic        break_i,
    output logic [15:0] min_o,
    output logic [15:0] max_o,
    output logic [31:0] sum_o,
    output logic [31:0] cnt_o,
    output logic [15:0] err_cnt_o,
    output logic        pass_o
);

    localparam int unsigned GR_W = $clog2(g_NUM_SUCCESSFUL_DATA + 2);

    logic [15:0]     min_q, min_d, max_q, max_d, err_q, err_d;
    logic [31:0]     sum_q, sum_d, cnt_q, cnt_d;
    logic [GR_W-1:0] good_q, good_d;
    logic            pass_q, pass_d;
    logic [32:0]     sum_ext;

    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            min_q  <= 16'hFFFF;
            max_q  <= '0;
            sum_q  <= '0;
            cnt_q  <= '0;
            err_q  <= '0;
            good_q <= '0;
            pass_q <= 1'b0;
        end else begin
            min_q  <= min_d;
            max_q  <= max_d;
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            good_q <= good_d;
            pass_q <= pass_d;
        end
    end

    // Clear overrides any sample or error arriving in the same cycle.
    always_comb begin
        min_d   = min_q;
        max_d   = max_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        good_d  = good_q;
        pass_d  = pass_q;
        sum_ext = {1'b0, sum_q} + 33'(latency_i);
        if (clear_i) begin
            min_d  = 16'hFFFF;
            max_d  = '0;
            sum_d  = '0;
            cnt_d  = '0;
            err_d  = '0;
            good_d = '0;
            pass_d = 1'b0;
        end else begin
            if (sample_i) begin
                if (latency_i < min_q) min_d = latency_i;
                if (latency_i > max_q) max_d = latency_i;
                sum_d = sum_ext[32] ? '1 : sum_ext[31:0];
                if (cnt_q != '1)  cnt_d  = cnt_q + 32'd1;
                if (good_q != '1) good_d = good_q + GR_W'(1);
            end
            if (err_i && (err_q != '1)) err_d = err_q + 16'd1;
            if (err_i || break_i) begin
                good_d = '0;
                pass_d = 1'b0;
            end else if (good_q > GR_W'(g_NUM_SUCCESSFUL_DATA)) begin
                pass_d = 1'b1;
            end
        end
    end

    assign min_o     = min_q;
    assign max_o     = max_q;
    assign sum_o     = sum_q;
    assign cnt_o     = cnt_q;
    assign err_cnt_o = err_q;
    assign pass_o    = pass_q;

endmodule

// File: rtl/gt_link_latency_monitor.sv
// GT loopback latency monitor: timestamped TX stream with periodic IDLE commas,
// RX alignment/integrity checker and latency statistics in usrclk cycles.
module gt_link_latency_monitor
    import gt_latency_pkg::*;
#(
    parameter int unsigned g_BYTES               = 2,
    parameter logic [15:0] g_IDLE                = 16'hbc95,
    parameter logic [1:0]  g_IDLE_K              = c_IDLE_LANE_K,
    parameter int unsigned g_IDLE_PERIOD         = 193,
    parameter int unsigned g_BLIND_PERIOD        = 10,
    parameter int unsigned g_NUM_SUCCESSFUL_DATA = 1000,
    parameter int unsigned g_TS_WIDTH            = 16
) (
    input  logic                      usrclk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    gt_link_latency_monitor_if.master gt,
    input  logic                      clear_stats_i,
    output logic [1:0]                state_o,
    output logic                      pass_o,
    output logic [15:0]               latency_min_o,
    output logic [15:0]               latency_max_o,
    output logic [31:0]               latency_sum_o,
    output logic [31:0]               sample_cnt_o,
    output logic [15:0]               err_cnt_o
);

    localparam int unsigned W    = 8 * g_BYTES;
    localparam int unsigned IC_W = (g_IDLE_PERIOD > 1) ? $clog2(g_IDLE_PERIOD) : 1;
    localparam int unsigned BL_W = (g_BLIND_PERIOD > 0) ? $clog2(g_BLIND_PERIOD + 1) : 1;

    localparam gt_word_t           c_IDLE_WORD = idle_word(g_BYTES, g_IDLE, g_IDLE_K);
    localparam logic [W-1:0]       c_IDLE_DATA = c_IDLE_WORD.data[W-1:0];
    localparam logic [g_BYTES-1:0] c_IDLE_K    = c_IDLE_WORD.k[g_BYTES-1:0];

    logic [g_TS_WIDTH-1:0] ts_q, ts_d;
    logic [IC_W-1:0]       cnt_idle_q, cnt_idle_d;
    logic [W-1:0]          tx_data_q, tx_data_d;
    logic [g_BYTES-1:0]    tx_k_q, tx_k_d;
    logic                  realign_q, realign_d;
    chk_state_e            state_q, state_d;
    logic [BL_W-1:0]       blind_q, blind_d;

    logic [31:0]           pay32, rx32;
    logic [15:0]           lane0, lane1;
    logic [g_TS_WIDTH-1:0] lat_c;
    logic                  rx_idle_c, rx_k0_c, lane1_bad_c;
    logic                  sample_c, err_c, break_c;

    always_ff @(posedge usrclk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_q       <= '0;
            cnt_idle_q <= '0;
            tx_data_q  <= c_IDLE_DATA;
            tx_k_q     <= c_IDLE_K;
            realign_q  <= 1'b0;
            state_q    <= ST_UNALIGNED;
            blind_q    <= '0;
        end else begin
            ts_q       <= ts_d;
            cnt_idle_q <= cnt_idle_d;
            tx_data_q  <= tx_data_d;
            tx_k_q     <= tx_k_d;
            realign_q  <= realign_d;
            state_q    <= state_d;
            blind_q    <= blind_d;
        end
    end

    // TX generator: lane0 carries the timestamp, lane1 (4-byte mode) its complement.
    always_comb begin
        ts_d       = ts_q + g_TS_WIDTH'(1);
        cnt_idle_d = (cnt_idle_q == IC_W'(g_IDLE_PERIOD - 1)) ? '0 : cnt_idle_q + IC_W'(1);
        pay32      = {~16'(ts_q), 16'(ts_q)};
        tx_data_d  = pay32[W-1:0];
        tx_k_d     = '0;
        if (!valid_i || (cnt_idle_q == '0)) begin
            tx_data_d = c_IDLE_DATA;
            tx_k_d    = c_IDLE_K;
        end
        realign_d = valid_i && !gt.rx_aligned_i;
    end

    always_comb begin
        rx32        = 32'(gt.rx_data_i);
        lane0       = rx32[15:0];
        lane1       = rx32[31:16];
        lat_c       = ts_q - lane0[g_TS_WIDTH-1:0];
        rx_idle_c   = (gt.rx_data_i == c_IDLE_DATA) && (gt.rx_k_i == c_IDLE_K);
        rx_k0_c     = (gt.rx_k_i == '0);
        lane1_bad_c = (g_BYTES == 4) && (lane1 != ~lane0);
    end

    // Checker FSM; losing alignment pre-empts every other transition.
    always_comb begin
        state_d  = state_q;
        blind_d  = blind_q;
        sample_c = 1'b0;
        err_c    = 1'b0;
        if (!gt.rx_aligned_i) begin
            state_d = ST_UNALIGNED;
        end else begin
            case (state_q)
                ST_UNALIGNED: begin
                    state_d = ST_BLIND;
                    blind_d = '0;
                end
                ST_BLIND: begin
                    if (blind_q == BL_W'(g_BLIND_PERIOD)) state_d = ST_SYNC;
                    else                                   blind_d = blind_q + BL_W'(1);
                end
                ST_SYNC: begin
                    if (rx_idle_c)     state_d = ST_CHECK;
                    else if (!rx_k0_c) err_c   = 1'b1;
                end
                ST_CHECK: begin
                    if (rx_k0_c) begin
                        if (lane1_bad_c) begin
                            err_c   = 1'b1;
                            state_d = ST_SYNC;
                        end else begin
                            sample_c = 1'b1;
                        end
                    end else if (!rx_idle_c) begin
                        err_c   = 1'b1;
                        state_d = ST_SYNC;
                    end
                end
                default: state_d = ST_UNALIGNED;
            endcase
        end
        break_c = (state_d != ST_CHECK);
    end

    gt_latency_stats #(
        .g_NUM_SUCCESSFUL_DATA(g_NUM_SUCCESSFUL_DATA)
    ) u_stats (
        .usrclk_i  (usrclk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_stats_i),
        .sample_i  (sample_c),
        .latency_i (16'(lat_c)),
        .err_i     (err_c),
        .break_i   (break_c),
        .min_o     (latency_min_o),
        .max_o     (latency_max_o),
        .sum_o     (latency_sum_o),
        .cnt_o     (sample_cnt_o),
        .err_cnt_o (err_cnt_o),
        .pass_o    (pass_o)
    );

    assign gt.tx_data_o    = tx_data_q;
    assign gt.tx_k_o       = tx_k_q;
    assign gt.rx_realign_o = realign_q;
    assign state_o         = state_q;

endmodule
